// File: rtl/mem_copy_engine_pkg.sv
// rtl/mem_copy_engine_pkg.sv - shared state encoding and memory timing constants for mem_copy_engine
package mem_copy_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int RD_CAPTURE = 3;
  localparam int RD_BUSY    = 5;
  localparam int WR_BUSY    = 4;

  localparam int PH_W = 3;

  // Counter is loaded during the strobe cycle and counts down to 1 on the last wait cycle.
  localparam logic [PH_W-1:0] PH_RD_LOAD  = PH_W'(RD_BUSY - 1);
  localparam logic [PH_W-1:0] PH_WR_LOAD  = PH_W'(WR_BUSY - 1);
  localparam logic [PH_W-1:0] PH_CAPTURE  = PH_W'(RD_BUSY - RD_CAPTURE);
  localparam logic [PH_W-1:0] PH_ONE      = PH_W'(1);

endpackage

// File: rtl/memcopy_phase_ctr.sv
// rtl/memcopy_phase_ctr.sv - loadable down-counter giving capture/expiry flags for the wait states
module memcopy_phase_ctr
  import mem_copy_engine_pkg::*;
(
  input  logic            Clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [PH_W-1:0] load_val,
  output logic            capture,
  output logic            expired
);

  logic [PH_W-1:0] cnt;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - PH_ONE;
    end
  end

  assign capture = (cnt == PH_CAPTURE);
  assign expired = (cnt == PH_ONE);

endmodule

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - strobe-and-wait block copy engine; MEMCOPY_CHKSUM_EN adds a running checksum
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          rd,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          wr,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
`ifdef MEMCOPY_CHKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);

  state_t          state;
  logic [AW:0]     remaining;
  logic            ph_load;
  logic [PH_W-1:0] ph_val;
  logic            ph_capture;
  logic            ph_expired;

  assign ph_load = (state == ST_RD) || (state == ST_WR);
  assign ph_val  = (state == ST_RD) ? PH_RD_LOAD : PH_WR_LOAD;

  memcopy_phase_ctr u_phase_ctr (
    .Clk      (Clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .capture  (ph_capture),
    .expired  (ph_expired)
  );

  // rd_addr/wr_addr double as the running source/destination pointers.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
`ifdef MEMCOPY_CHKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr   <= src_addr;
            wr_addr   <= dst_addr;
            remaining <= len;
`ifdef MEMCOPY_CHKSUM_EN
            checksum  <= '0;
`endif
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RD;
              rd    <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          rd    <= 1'b0;
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (ph_capture) begin
            wr_data  <= rd_data;
`ifdef MEMCOPY_CHKSUM_EN
            checksum <= checksum + rd_data;
`endif
          end
          if (ph_expired) begin
            state <= ST_WR;
            wr    <= 1'b1;
          end
        end
        ST_WR: begin
          wr    <= 1'b0;
          state <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (ph_expired) begin
            rd_addr   <= rd_addr + ADDR_ONE;
            wr_addr   <= wr_addr + ADDR_ONE;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_RD;
              rd    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine with a timed ROM model and RAM model
module tb_mem_copy_engine;

  logic       Clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] src_addr, dst_addr;
  logic [8:0] len;
  logic       busy, done, rd, wr;
  logic [7:0] rd_addr, rd_data, wr_addr, wr_data;
`ifdef MEMCOPY_CHKSUM_EN
  logic [7:0] checksum;
`endif

  always #5 Clk = ~Clk;

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .Clk      (Clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd       (rd),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr       (wr),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
`ifdef MEMCOPY_CHKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // ROM: mem[i] = 255-i; data valid only between read edges E2 and E4, inverted garbage otherwise.
  logic [7:0] rom [256];
  logic [7:0] ram [256];
  int         rom_ph = 0;
  logic [7:0] rom_a = 8'd0;

  initial for (int i = 0; i < 256; i++) rom[i] = 8'(255 - i);

  always @(posedge Clk) begin
    if (rd) begin
      rom_ph <= 1;
      rom_a  <= rd_addr;
    end else if (rom_ph >= 1 && rom_ph <= 4) begin
      rom_ph <= rom_ph + 1;
    end else begin
      rom_ph <= 0;
    end
  end

  assign rd_data = (rom_ph == 3 || rom_ph == 4) ? rom[rom_a] : ~rom[rom_a];

  always @(posedge Clk) if (wr) ram[wr_addr] <= wr_data;

  int q_rd_cyc[$], q_rd_addr[$];
  int q_wr_cyc[$], q_wr_addr[$], q_wr_data[$];
  int q_done_cyc[$], q_sum[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush();
    q_rd_cyc.delete();   q_rd_addr.delete();
    q_wr_cyc.delete();   q_wr_addr.delete(); q_wr_data.delete();
    q_done_cyc.delete(); q_sum.delete();
  endtask

  // Monitor: pops expectations whenever the DUT shows a strobe or done.
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  int   mon_sum;
  always @(negedge Clk) begin
    if (rd || wr) begin
      chk("rd_wr_overlap", int'(rd && wr), 0);
      chk("strobe_held", int'((rd && prev_rd) || (wr && prev_wr)), 0);
    end
    if (rd) begin
      if (q_rd_cyc.size() == 0) chk("unexpected_rd", 1, 0);
      else begin
        chk("rd_cycle", cyc, q_rd_cyc.pop_front());
        chk("rd_addr", int'(rd_addr), q_rd_addr.pop_front());
        chk("busy_at_rd", int'(busy), 1);
      end
    end
    if (wr) begin
      if (q_wr_cyc.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        chk("wr_cycle", cyc, q_wr_cyc.pop_front());
        chk("wr_addr", int'(wr_addr), q_wr_addr.pop_front());
        chk("wr_data", int'(wr_data), q_wr_data.pop_front());
        chk("busy_at_wr", int'(busy), 1);
      end
    end
    if (done) begin
      if (q_done_cyc.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("done_cycle", cyc, q_done_cyc.pop_front());
        chk("busy_at_done", int'(busy), 0);
        chk("pending_rd_at_done", q_rd_cyc.size(), 0);
        mon_sum = q_sum.pop_front();
`ifdef MEMCOPY_CHKSUM_EN
        chk("checksum", int'(checksum), mon_sum);
`endif
      end
    end
    prev_rd <= rd;
    prev_wr <= wr;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd"}, int'(rd), 0);
    chk({tag, "_wr"}, int'(wr), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
`ifdef MEMCOPY_CHKSUM_EN
    chk({tag, "_checksum"}, int'(checksum), 0);
`endif
  endtask

  // Issues a start and queues the reference schedule: byte n reads at 1+9n, writes at 6+9n.
  task automatic issue(input int s, input int d, input int l);
    int c, sum, a;
    @(posedge Clk); #1;
    c = cyc;
    sum = 0;
    for (int n = 0; n < l; n++) begin
      a = (s + n) % 256;
      q_rd_cyc.push_back(c + 1 + 9 * n);
      q_rd_addr.push_back(a);
      q_wr_cyc.push_back(c + 6 + 9 * n);
      q_wr_addr.push_back((d + n) % 256);
      q_wr_data.push_back(int'(rom[a]));
      sum += int'(rom[a]);
    end
    q_done_cyc.push_back(c + 9 * l + 1);
    q_sum.push_back(sum % 256);
    start = 1'b1; src_addr = 8'(s); dst_addr = 8'(d); len = 9'(l);
    @(posedge Clk); #1;
    start = 1'b0;
    src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 9'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (q_done_cyc.size() != 0 && k < budget) begin
      @(negedge Clk); #1;
      k++;
    end
    if (q_done_cyc.size() != 0) begin
      chk("done_timeout", 1, 0);
      flush();
    end
  endtask

  task automatic check_ram(input int s, input int d, input int l);
    for (int n = 0; n < l; n++)
      chk("ram_byte", int'(ram[(d + n) % 256]), int'(rom[(s + n) % 256]));
  endtask

  initial begin
    int s, d, l;
    rst_n = 1'b0; start = 1'b0; src_addr = 8'd0; dst_addr = 8'd0; len = 9'd0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    issue(73, 10, 3);
    wait_done(60);
    chk("ram10", int'(ram[10]), 182);
    chk("ram11", int'(ram[11]), 181);
    chk("ram12", int'(ram[12]), 180);

    // start during the done cycle must be ignored
    start = 1'b1; src_addr = 8'd0; dst_addr = 8'd0; len = 9'd1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (15) @(posedge Clk);
    #1;
    chk("idle_after_done_start", int'(busy), 0);

    issue(5, 6, 0);
    chk("len0_busy", int'(busy), 0);
    chk("len0_done", int'(done), 1);
    wait_done(10);

    issue(254, 255, 4);
    wait_done(60);
    check_ram(254, 255, 4);

    issue(20, 100, 2);
    repeat (4) @(posedge Clk);
    #1;
    start = 1'b1; src_addr = 8'd200; dst_addr = 8'd201; len = 9'd5;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_done(40);
    check_ram(20, 100, 2);

    issue(30, 40, 3);
    repeat (6) @(posedge Clk);
    #3;
    flush();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge Clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge Clk);
    issue(50, 60, 1);
    wait_done(30);
    check_ram(50, 60, 1);

    s = int'($urandom_range(0, 255));
    d = int'($urandom_range(0, 255));
    issue(s, d, 256);
    wait_done(2400);
    check_ram(s, d, 256);

    for (int i = 0; i < 6; i++) begin
      s = int'($urandom_range(0, 255));
      d = int'($urandom_range(0, 255));
      l = int'($urandom_range(1, 8));
      issue(s, d, l);
      wait_done(9 * l + 20);
      check_ram(s, d, l);
    end

    repeat (5) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Copy engine that moves a block of bytes from a read-only source memory into a writable destination memory. It drives the source read port and the destination write port using the team's strobe-and-wait memory protocol. A single `start` launches a copy of `len` bytes from `src_addr` to `dst_addr`, and a `done` pulse reports completion. It sits directly upstream of the ROM/RAM blocks, replacing hand-written testbench sequencing of `rd`/`wr`.

## Interface
- `AW`, 8: address width; all addresses wrap modulo 2^AW.
- `DW`, 8: data width.
- `Clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launch a copy; sampled only in IDLE.
- `src_addr`  in  AW  first source address; captured at start.
- `dst_addr`  in  AW  first destination address; captured at start.
- `len`  in  AW+1  byte count, 0..2^AW; captured at start.
- `busy`  out  1  high from the cycle after start until the done cycle.
- `done`  out  1  one-cycle completion pulse.
- `rd`  out  1  source read strobe; one-cycle pulse.
- `rd_addr`  out  AW  source address; held stable while `rd`=1.
- `rd_data`  in  DW  source data; valid from read edge E2 to E4.
- `wr`  out  1  destination write strobe; one-cycle pulse.
- `wr_addr`  out  AW  destination address; held while `wr`=1.
- `wr_data`  out  DW  destination data; held while `wr`=1.
- `checksum`  out  DW  running sum; present only with `MEMCOPY_CHKSUM_EN`.

## Operation
- States:
  - IDLE.
  - RD: `rd`=1 for one cycle.
  - RD_WAIT: phase counter 1..4; `rd_data` is captured into the data register at read edge E3.
  - WR: `wr`=1 for one cycle, with `wr_data` = captured byte.
  - WR_WAIT: phase counter 1..3.
  - DONE: `done`=1 for one cycle, then IDLE.
- IDLE + `start`=1:
  - Latch src/dst/len and go to RD; with `len`=0, go to DONE instead.
- After WR_WAIT:
  - Increment src and dst modulo 2^AW and decrement the remaining count.
  - Remaining count 0 → DONE; otherwise → RD.
- `start` is ignored in every state other than IDLE. A start in the DONE cycle is ignored.
- `rd` and `wr` are never high in the same cycle. Neither strobe is ever held for two consecutive cycles, because the memories re-trigger on a held strobe.
- Reset, including mid-copy:
  - Every output returns to 0 immediately and the state returns to IDLE.
  - A memory operation already in flight completes on its own side.
  - The engine issues nothing until a new `start`.
- Reset values: `busy`=0, `done`=0, `rd`=0, `wr`=0, `rd_addr`=0, `wr_addr`=0, `wr_data`=0, `checksum`=0.

## Timing
- Memory contract: a strobe is sampled at edge E0, and the memory accepts no new command before:
  - read: E5; data appears at E2 and goes high-Z at E4.
  - write: E4; the location is updated at E2.
- Cycle numbering: the start edge ends cycle 0.
- Byte n (0-based):
  - `rd` high in cycle 1+9n.
  - Data captured at the end of cycle 4+9n.
  - `wr` high in cycle 6+9n.
  - The next `rd` is at cycle 10+9n.
- Fixed throughput: 9 cycles per byte.
- `done` is high in cycle 9·len+1; `busy` is 0 in that cycle.
- With `len`=0, `done` is high in cycle 1.
- The source and destination may be the same device; the spacing above already respects read and write busy windows.

## Configuration
- `MEMCOPY_CHKSUM_EN` defined:
  - `checksum` is cleared to 0 at start.
  - Each captured byte is added modulo 2^DW in the capture cycle.
  - The value is valid in the done cycle and holds until the next start.
- `MEMCOPY_CHKSUM_EN` undefined: the `checksum` port and its adder are absent.

## Structure
- Shared package: state encoding (IDLE, RD, RD_WAIT, WR, WR_WAIT, DONE) and the timing constants RD_CAPTURE=3, RD_BUSY=5, WR_BUSY=4.
- One sub-module, `memcopy_phase_ctr`:
  - Loadable down-counter producing the capture and expiry flags for the wait states.
  - Reset asynchronously by `rst_n`.

## Test plan
- ROM holding mem[i]=255−i; start with src=73, dst=10, len=3:
  - RAM[10..12] = 182, 181, 180.
  - `rd` pulses at cycles 1, 10, 19; `wr` pulses at cycles 6, 15, 24.
  - `done` at cycle 28.
- `len`=0 → `done` at cycle 1; no `rd`/`wr` activity; `busy` never high.
- src=254, len=4 → `rd_addr` sequence 254, 255, 0, 1; dst=255 → `wr_addr` sequence 255, 0, 1, 2.
- Second `start` with different addresses at cycle 5 of a len=2 copy → ignored; the copy completes unchanged with `done` at cycle 19.
- `rst_n` low at cycle 7 of a len=3 copy:
  - Outputs drop to 0 asynchronously.
  - A new start with len=1 afterwards completes cleanly with `done` at cycle 10.
- With `MEMCOPY_CHKSUM_EN`, the first scenario gives `checksum`=31 (543 mod 256) in the done cycle.
